// File: rtl/load_store_unit_if.sv
// Request/response and memory-side bundles for the load/store unit.
// lsuReqIf: MEM stage (master) <-> load_store_unit (slave); valid/ready request, one-cycle response pulse.
// lsuMemIf: load_store_unit (master) <-> word memory (slave); read/write enables, word index, write/read data.

interface lsuReqIf;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;
    logic        respValid;
    logic [31:0] respData;
    logic        respFault;

    modport master (
        output reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqWriteData,
        input  reqReady, respValid, respData, respFault
    );

    modport slave (
        input  reqValid, reqWrite, reqSize, reqSigned, reqAddress, reqWriteData,
        output reqReady, respValid, respData, respFault
    );
endinterface

interface lsuMemIf;
    logic        memReadFlag;
    logic        memWriteFlag;
    logic [31:0] MemAddress;
    logic [31:0] WriteDataInput;
    logic [31:0] ReadDataOutput;

    modport master (
        output memReadFlag, memWriteFlag, MemAddress, WriteDataInput,
        input  ReadDataOutput
    );

    modport slave (
        input  memReadFlag, memWriteFlag, MemAddress, WriteDataInput,
        output ReadDataOutput
    );
endinterface

// File: rtl/load_store_unit.sv
// Purpose: byte/half/word load-store initiator for a word-organised memory, read-modify-write for sub-word stores.
// Latency: response 1 cycle after accept on fault, 2 for loads and word stores, 3 for sub-word stores.
// Backpressure: one request in flight; reqReady only in IDLE, reqValid while busy is ignored, never queued.
// Ports: clk, rst_n (async active-low); req = lsuReqIf.slave (request + response pulse);
//        mem = lsuMemIf.master (read/write flags, word index, write data, combinational read data).

module load_store_unit #(
    parameter int MEM_WORDS_LOG2 = 7,
    parameter bit RANGE_CHECK    = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    lsuReqIf.slave   req,
    lsuMemIf.master  mem
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsuStateT;

    localparam logic [29:0] WORD_LIMIT = 30'(64'(1) << MEM_WORDS_LOG2);

    lsuStateT    state, nextState;
    logic        opWrite;
    logic [1:0]  opSize;
    logic        opSigned;
    logic [1:0]  opLane;
    logic [31:0] opWriteData;
    logic [31:0] memAddressQ;
    logic [31:0] writeDataQ;
    logic [31:0] respDataQ;
    logic        respFaultQ;

    logic        accept;
    logic        reqFault;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] loadValue;
    logic [31:0] mergedWord;

    assign accept = req.reqValid && (state == IDLE);

    always_comb begin
        reqFault = 1'b0;
        case (req.reqSize)
            2'b01:   reqFault = req.reqAddress[0];
            2'b10:   reqFault = (req.reqAddress[1:0] != 2'b00);
            2'b11:   reqFault = 1'b1;
            default: reqFault = 1'b0;
        endcase
        if (RANGE_CHECK && (req.reqAddress[31:2] >= WORD_LIMIT)) begin
            reqFault = 1'b1;
        end
    end

    // Word stores skip the read; sub-word stores read first so the untouched lanes can be merged back.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reqFault)                                    nextState = RESP;
                    else if (req.reqWrite && req.reqSize == 2'b10)   nextState = WR;
                    else                                             nextState = RD;
                end
            end
            RD:      nextState = opWrite ? WR : RESP;
            WR:      nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Little-endian lane extraction from the word presented during RD.
    assign loadByte = mem.ReadDataOutput[{opLane, 3'b000} +: 8];
    assign loadHalf = mem.ReadDataOutput[{opLane[1], 4'b0000} +: 16];

    always_comb begin
        loadValue = mem.ReadDataOutput;
        case (opSize)
            2'b00:   loadValue = opSigned ? {{24{loadByte[7]}}, loadByte} : {24'b0, loadByte};
            2'b01:   loadValue = opSigned ? {{16{loadHalf[15]}}, loadHalf} : {16'b0, loadHalf};
            default: loadValue = mem.ReadDataOutput;
        endcase
    end

    always_comb begin
        mergedWord = mem.ReadDataOutput;
        if (opSize == 2'b00) begin
            mergedWord[{opLane, 3'b000} +: 8] = opWriteData[7:0];
        end else begin
            mergedWord[{opLane[1], 4'b0000} +: 16] = opWriteData[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            opWrite     <= 1'b0;
            opSize      <= 2'b00;
            opSigned    <= 1'b0;
            opLane      <= 2'b00;
            opWriteData <= '0;
            memAddressQ <= '0;
            writeDataQ  <= '0;
            respDataQ   <= '0;
            respFaultQ  <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                opWrite     <= req.reqWrite;
                opSize      <= req.reqSize;
                opSigned    <= req.reqSigned;
                opLane      <= req.reqAddress[1:0];
                opWriteData <= req.reqWriteData;
                memAddressQ <= {2'b00, req.reqAddress[31:2]};
                respDataQ   <= '0;
                respFaultQ  <= reqFault;
                if (!reqFault && req.reqWrite && req.reqSize == 2'b10) begin
                    writeDataQ <= req.reqWriteData;
                end
            end else if (state == RD) begin
                if (opWrite) begin
                    writeDataQ <= mergedWord;
                end else begin
                    respDataQ <= loadValue;
                end
            end
        end
    end

    // All outputs decode registered state only.
    assign req.reqReady       = (state == IDLE);
    assign req.respValid      = (state == RESP);
    assign req.respData       = (state == RESP) ? respDataQ : 32'h0;
    assign req.respFault      = (state == RESP) && respFaultQ;
    assign mem.memReadFlag    = (state == RD);
    assign mem.memWriteFlag   = (state == WR);
    assign mem.MemAddress     = memAddressQ;
    assign mem.WriteDataInput = writeDataQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios then randomized requests against a byte-array model.
// Inputs driven on falling edges, outputs sampled on falling edges.
// Ends with one summary line of checks and errors.

module tb_load_store_unit;

    logic clk;
    logic rst_n;

    lsuReqIf reqBus ();
    lsuMemIf memBus ();

    load_store_unit #(
        .MEM_WORDS_LOG2 (7),
        .RANGE_CHECK    (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (reqBus),
        .mem   (memBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory seen by the DUT, with a backdoor write port for preloading.
    logic [31:0] mem [128];
    logic        bdWe;
    logic [6:0]  bdIdx;
    logic [31:0] bdVal;
    int          writeCount;

    assign memBus.ReadDataOutput = mem[memBus.MemAddress[6:0]];

    always @(posedge clk) begin
        if (bdWe) begin
            mem[bdIdx] <= bdVal;
        end else if (memBus.memWriteFlag) begin
            mem[memBus.MemAddress[6:0]] <= memBus.WriteDataInput;
            writeCount <= writeCount + 1;
        end
    end

    // Reference model: plain byte-addressed memory.
    logic [7:0] refMem [512];

    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refWord(input logic [31:0] a);
        int base;
        base = int'({a[8:2], 2'b00});
        return {refMem[base + 3], refMem[base + 2], refMem[base + 1], refMem[base]};
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n;
        int base;
        logic [31:0] v;
        n    = sizeBytes(sz);
        base = int'(a[8:0]);
        v    = '0;
        for (int i = 0; i < n; i++) v = v | (32'(refMem[base + i]) << (8 * i));
        if (sg && n < 4 && v[8 * n - 1]) begin
            for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic refStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n;
        int base;
        n    = sizeBytes(sz);
        base = int'(a[8:0]);
        for (int i = 0; i < n; i++) refMem[base + i] = d[8 * i +: 8];
    endtask

    task automatic setWord(input logic [6:0] idx, input logic [31:0] val);
        for (int i = 0; i < 4; i++) refMem[int'(idx) * 4 + i] = val[8 * i +: 8];
        bdIdx = idx;
        bdVal = val;
        bdWe  = 1'b1;
        @(negedge clk);
        bdWe  = 1'b0;
    endtask

    // Issues one request from an IDLE falling edge and checks every cycle up to and including RESP.
    // Returns at the falling edge of the following IDLE cycle.
    task automatic doReq(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] d, input bit hold, output logic [31:0] rdata);
        logic        fault;
        logic        sub;
        int          lat;
        logic [31:0] expData;
        logic [31:0] expWr;
        logic        expRd;
        logic        expWrF;

        fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
                || (a[31:2] >= 30'd128);
        sub   = w && (sz != 2'b10);
        lat   = fault ? 1 : (sub ? 3 : 2);
        expData = '0;
        expWr   = '0;
        if (!fault) begin
            if (w) begin
                refStore(a, sz, d);
                expWr = refWord(a);
            end else begin
                expData = refLoad(a, sz, sg);
            end
        end

        reqBus.reqValid     = 1'b1;
        reqBus.reqWrite     = w;
        reqBus.reqSize      = sz;
        reqBus.reqSigned    = sg;
        reqBus.reqAddress   = a;
        reqBus.reqWriteData = d;
        checkBit("ready_before_accept", reqBus.reqReady, 1'b1);
        @(negedge clk);
        if (hold) begin
            // Busy-time garbage that must be neither accepted nor sampled.
            reqBus.reqWrite     = 1'($urandom_range(0, 1));
            reqBus.reqSize      = 2'($urandom_range(0, 3));
            reqBus.reqSigned    = 1'($urandom_range(0, 1));
            reqBus.reqAddress   = $urandom;
            reqBus.reqWriteData = $urandom;
        end else begin
            reqBus.reqValid = 1'b0;
        end

        for (int k = 1; k <= lat; k++) begin
            expRd  = !fault && (k == 1) && (!w || sub);
            expWrF = !fault && w && (k == (sub ? 2 : 1));
            checkBit("memReadFlag", memBus.memReadFlag, expRd);
            checkBit("memWriteFlag", memBus.memWriteFlag, expWrF);
            checkBit("ready_busy", reqBus.reqReady, 1'b0);
            check("MemAddress", memBus.MemAddress, {2'b00, a[31:2]});
            if (expWrF) check("WriteDataInput", memBus.WriteDataInput, expWr);
            if (k == lat) begin
                checkBit("respValid", reqBus.respValid, 1'b1);
                checkBit("respFault", reqBus.respFault, fault);
                check("respData", reqBus.respData, expData);
                rdata = reqBus.respData;
            end else begin
                checkBit("respValid_early", reqBus.respValid, 1'b0);
                check("respData_idle", reqBus.respData, 32'h0);
            end
            @(negedge clk);
        end
        checkBit("ready_after_resp", reqBus.reqReady, 1'b1);
        checkBit("respValid_after", reqBus.respValid, 1'b0);
        checkBit("respFault_after", reqBus.respFault, 1'b0);
        if (!hold) reqBus.reqValid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [1:0]  sz;
        int          wc;
        int          pick;

        checks = 0;
        errors = 0;
        writeCount = 0;
        bdWe  = 1'b0;
        bdIdx = '0;
        bdVal = '0;
        reqBus.reqValid     = 1'b0;
        reqBus.reqWrite     = 1'b0;
        reqBus.reqSize      = 2'b00;
        reqBus.reqSigned    = 1'b0;
        reqBus.reqAddress   = '0;
        reqBus.reqWriteData = '0;
        rst_n = 1'b0;

        // Reset state
        #12;
        checkBit("rst_reqReady", reqBus.reqReady, 1'b1);
        checkBit("rst_respValid", reqBus.respValid, 1'b0);
        checkBit("rst_respFault", reqBus.respFault, 1'b0);
        check("rst_respData", reqBus.respData, 32'h0);
        checkBit("rst_memReadFlag", memBus.memReadFlag, 1'b0);
        checkBit("rst_memWriteFlag", memBus.memWriteFlag, 1'b0);
        check("rst_MemAddress", memBus.MemAddress, 32'h0);
        check("rst_WriteDataInput", memBus.WriteDataInput, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 128; i++) setWord(7'(i), $urandom);

        // 1: word load
        setWord(7'd3, 32'h11223344);
        doReq(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, r);
        check("t1_lw", r, 32'h11223344);

        // 2: byte loads, signed and unsigned
        doReq(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 1'b0, r);
        check("t2_lb_pos", r, 32'h00000022);
        setWord(7'd3, 32'h11A23344);
        doReq(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 1'b0, r);
        check("t2_lb_neg", r, 32'hFFFFFFA2);
        doReq(1'b0, 2'b00, 1'b0, 32'h0E, 32'h0, 1'b0, r);
        check("t2_lbu", r, 32'h000000A2);

        // 3: byte store with read-modify-write, then readback
        setWord(7'd3, 32'h11223344);
        doReq(1'b1, 2'b00, 1'b0, 32'h0D, 32'hFFFFFFAB, 1'b0, r);
        doReq(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, r);
        check("t3_readback", r, 32'h1122AB44);

        // 4: faults leave memory untouched
        wc = writeCount;
        doReq(1'b0, 2'b01, 1'b0, 32'h0D, 32'h0, 1'b0, r);
        doReq(1'b1, 2'b10, 1'b0, 32'h06, 32'hDEADBEEF, 1'b0, r);
        doReq(1'b1, 2'b11, 1'b0, 32'h0C, 32'hDEADBEEF, 1'b0, r);
        doReq(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, r);
        doReq(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, r);
        check("t4_no_writes", 32'(writeCount - wc), 32'h0);
        doReq(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, r);
        check("t4_mem_unchanged", r, 32'h1122AB44);

        // 5: back-to-back stores with reqValid held high
        doReq(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b1, r);
        doReq(1'b1, 2'b00, 1'b0, 32'h25, 32'h0000005A, 1'b1, r);
        doReq(1'b1, 2'b01, 1'b0, 32'h2A, 32'h0000BEEF, 1'b1, r);
        reqBus.reqValid = 1'b0;
        doReq(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, r);
        check("t5_word", r, 32'hCAFEF00D);
        doReq(1'b0, 2'b00, 1'b0, 32'h25, 32'h0, 1'b0, r);
        check("t5_byte", r, 32'h0000005A);
        doReq(1'b0, 2'b01, 1'b1, 32'h2A, 32'h0, 1'b0, r);
        check("t5_half", r, 32'hFFFFBEEF);

        // 6: reset during the read phase of a halfword store
        setWord(7'd4, 32'h55667788);
        wc = writeCount;
        reqBus.reqValid     = 1'b1;
        reqBus.reqWrite     = 1'b1;
        reqBus.reqSize      = 2'b01;
        reqBus.reqSigned    = 1'b0;
        reqBus.reqAddress   = 32'h12;
        reqBus.reqWriteData = 32'h0000ABCD;
        @(negedge clk);
        reqBus.reqValid = 1'b0;
        checkBit("t6_in_rd", memBus.memReadFlag, 1'b1);
        rst_n = 1'b0;
        #1;
        checkBit("t6_rd_drop", memBus.memReadFlag, 1'b0);
        checkBit("t6_wr_low", memBus.memWriteFlag, 1'b0);
        checkBit("t6_ready", reqBus.reqReady, 1'b1);
        check("t6_addr_clr", memBus.MemAddress, 32'h0);
        check("t6_wdata_clr", memBus.WriteDataInput, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkBit("t6_no_resp", reqBus.respValid, 1'b0);
            checkBit("t6_no_write", memBus.memWriteFlag, 1'b0);
            checkBit("t6_ready_after", reqBus.reqReady, 1'b1);
        end
        check("t6_write_count", 32'(writeCount - wc), 32'h0);
        doReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r);
        check("t6_mem_unchanged", r, 32'h55667788);

        // Randomized requests against the byte model
        for (int n = 0; n < 80; n++) begin
            pick = int'($urandom_range(0, 19));
            sz = (pick < 6) ? 2'b00 : (pick < 12) ? 2'b01 : (pick < 19) ? 2'b10 : 2'b11;
            a = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) a = $urandom;
            doReq(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  bit'($urandom_range(0, 1)), r);
        end
        reqBus.reqValid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
